// File: rtl/sequential_buffer.sv
// -----------------------------------------------------------------------------
// sequential_buffer
//
// Synchronous FIFO. It stores up to DEPTH words in an array and uses
// wrap-around read and write pointers. A popped word is registered into
// data_out, and data_valid pulses for one cycle after the accepting edge.
//
// Request/accept semantics:
//   Requests are level-sampled on each rising clk edge. Nothing is ever
//   back-pressured or held: a request that cannot be accepted is dropped
//   for that cycle.
//   - A write is accepted when request_write=1 and either the buffer is not
//     full or a read is accepted in the same cycle.
//   - A read is accepted when request_read=1 and the buffer is not empty.
//   - A rejected write (full, no read) sets the sticky overflow flag.
//   - A rejected read (empty) sets the sticky underflow flag.
//
// Ports:
//   clk            sole clock, rising edge
//   reset          asynchronous, active-low reset
//   flush          synchronous discard of all stored entries; clears the
//                  error flags; read/write are ignored in that cycle
//   request_write  push data_in this cycle
//   request_read   pop oldest entry this cycle
//   data_in        word to push
//   data_out       registered popped word (held when no read is accepted)
//   data_valid     data_out was loaded by an accepted read on the last edge
//   full, empty, almost_full, almost_empty
//                  occupancy flags, decoded from the registered count
//   count          number of stored entries, 0..DEPTH
//   overflow, underflow
//                  sticky error flags, cleared by reset or flush
// -----------------------------------------------------------------------------
module sequential_buffer #(
    parameter int DATA_WIDTH         = 8,
    parameter int DEPTH              = 16,
    parameter int ALMOST_FULL_LEVEL  = DEPTH - 2,
    parameter int ALMOST_EMPTY_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     request_write,
    input  logic                     request_read,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;

    logic do_read;
    logic do_write;
    logic write_rejected;
    logic read_rejected;

    // Occupancy flags come straight from the registered count.
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(ALMOST_FULL_LEVEL));
    assign almost_empty = (count <= CW'(ALMOST_EMPTY_LEVEL));

    // When the buffer is full, a write is still accepted if a read is
    // accepted in the same cycle. The read frees a slot on the same edge
    // that the write fills it.
    assign do_read        = request_read && !empty;
    assign do_write       = request_write && (!full || do_read);
    assign write_rejected = request_write && full && !request_read;
    assign read_rejected  = request_read && empty;

    // Storage array. It has no reset: its contents are only visible
    // through the pointers, and the pointers are reset.
    always_ff @(posedge clk) begin
        if (do_write && !flush) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are AW bits wide and DEPTH is a power of two, so
            // incrementing past DEPTH-1 wraps them to 0.
            if (do_write) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_write, do_read})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Output register and valid pulse. data_out keeps its value through a
    // flush; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else if (flush) begin
            data_valid <= 1'b0;
        end else begin
            data_valid <= do_read;
            if (do_read) begin
                data_out <= mem[rd_ptr];
            end
        end
    end

    // Sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_rejected) begin
                overflow <= 1'b1;
            end
            if (read_rejected) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/sequential_buffer.md
SEQUENTIAL_BUFFER -- requirements
Module: sequential_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of each stored word.
REQ-002 SHALL have parameter DEPTH, default 16: number of entries; power of two, >= 2.
REQ-003 SHALL have parameter ALMOST_FULL_LEVEL, default DEPTH-2: count at or above which almost_full is asserted.
REQ-004 SHALL have parameter ALMOST_EMPTY_LEVEL, default 2: count at or below which almost_empty is asserted.
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port flush  input  1  synchronous discard of all stored entries.
REQ-008 SHALL have port request_write  input  1  push data_in this cycle.
REQ-009 SHALL have port request_read  input  1  pop oldest entry this cycle.
REQ-010 SHALL have port data_in  input  DATA_WIDTH  word to push.
REQ-011 SHALL have port data_out  output  DATA_WIDTH  registered popped word.
REQ-012 SHALL have port data_valid  output  1  data_out updated by an accepted read on the previous edge.
REQ-013 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  occupancy flags.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current number of stored entries.
REQ-015 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 SHALL store entries in FIFO order in a DEPTH-entry array with wrap-around write and read pointers.
REQ-017 SHALL accept a write when request_write=1 and (full=0 or an accepted read in the same cycle).
REQ-018 SHALL accept a read when request_read=1 and empty=0.
REQ-019 SHALL, on an accepted read, load the oldest entry into data_out and pulse data_valid=1 for exactly one cycle after the edge (latency 1).
REQ-020 SHALL hold data_out unchanged when no read is accepted; data_valid=0 in that cycle.
REQ-021 SHALL update count: +1 write only, -1 read only, unchanged for both or neither.
REQ-022 SHALL derive full (count==DEPTH), empty (count==0), almost_full (count>=ALMOST_FULL_LEVEL), almost_empty (count<=ALMOST_EMPTY_LEVEL) combinationally from registered count.
REQ-023 SHALL wrap each pointer from DEPTH-1 to 0.
REQ-024 SHALL, on simultaneous read and write when empty, accept only the write; set underflow; data_valid stays 0.
REQ-025 SHALL, on simultaneous read and write when full, accept both; count stays DEPTH.
REQ-026 SHALL, on write request while full without read, drop the word, leave state unchanged, set overflow.
REQ-027 SHALL, on read request while empty, leave state and data_out unchanged, set underflow.
REQ-028 SHALL keep overflow/underflow set until reset or flush.
REQ-029 SHALL, on flush=1, reset pointers, count, overflow, underflow and data_valid to 0, ignoring read/write in that cycle; data_out unchanged.

Reset
REQ-030 SHALL, while reset=0, asynchronously force pointers=0, count=0, data_out=0, data_valid=0, overflow=0, underflow=0, hence empty=1, full=0, almost_empty=1, almost_full=0.
REQ-031 SHALL abandon any operation in progress when reset asserts mid-operation; array contents need not be cleared.
REQ-032 SHALL resume normal operation on the first rising clk edge after reset deasserts.

Verification (DATA_WIDTH=8, DEPTH=4, ALMOST_FULL_LEVEL=3, ALMOST_EMPTY_LEVEL=1)
REQ-033 SHALL cover: reset then read on empty -> data_out=0, data_valid=0, underflow=1, count=0.
REQ-034 SHALL cover: write 0x03,0x06,0x09,0x0C then 5th write 0x0F -> full=1, almost_full=1, overflow=1, count=4; four reads return 0x03,0x06,0x09,0x0C each with data_valid one cycle later, then empty=1.
REQ-035 SHALL cover: six write/read pairs interleaved past pointer wrap -> read order equals write order, count never exceeds 2.
REQ-036 SHALL cover: full, simultaneous read+write 0xAA -> read returns oldest word, count stays 4, overflow unchanged; 0xAA later read in order.
REQ-037 SHALL cover: empty, simultaneous read+write 0x55 -> count=1, data_valid=0, underflow=1; next read returns 0x55.
REQ-038 SHALL cover: count=2 then flush, then reset=0 asserted mid-write -> count=0, empty=1, flags 0, no data_valid pulse.
